// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
// Imported by the divider top; holds widths, state codes and handshake levels.
package div_pkg;

  localparam int DefaultDataWidth  = 32;
  localparam int DefaultCountWidth = 6;
  localparam int DoubleRegisterBus = 2 * DefaultDataWidth;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} held until EX drops start.
module div
  import div_pkg::*;
#(
  parameter int DataWidth  = DefaultDataWidth,
  parameter int CountWidth = DefaultCountWidth
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   signed_div_input,
  input  logic [DataWidth-1:0]   opdata1_input,
  input  logic [DataWidth-1:0]   opdata2_input,
  input  logic                   start_input,
  input  logic                   annul_input,
  output logic [2*DataWidth-1:0] result_output,
  output logic                   ready_output
);

  localparam int DivW = 2 * DataWidth + 1;
  localparam logic [CountWidth-1:0] LastCount  = CountWidth'(DataWidth);
  localparam logic [CountWidth-1:0] CountZero  = {CountWidth{1'b0}};
  localparam logic [CountWidth-1:0] CountOne   = {{(CountWidth-1){1'b0}}, 1'b1};
  localparam logic [2*DataWidth-1:0] ZeroResult = {(2*DataWidth){1'b0}};
  localparam logic [DivW-1:0]        ZeroDividend = {DivW{1'b0}};

  div_state_e r_state, w_state_nxt;

  logic [CountWidth-1:0]  r_count, w_count_nxt;
  logic [DivW-1:0]        r_dividend, w_dividend_nxt;
  logic [DataWidth-1:0]   r_divisor, w_divisor_nxt;
  logic                   r_op1_neg, w_op1_neg_nxt;
  logic                   r_op2_neg, w_op2_neg_nxt;
  logic [2*DataWidth-1:0] w_result_nxt;
  logic                   w_ready_nxt;

  logic                   w_op1_neg, w_op2_neg;
  logic [DataWidth-1:0]   w_op1_abs, w_op2_abs;
  logic [DataWidth:0]     w_minuend;
  logic [DataWidth-1:0]   w_diff;
  logic                   w_borrow;
  logic [DataWidth-1:0]   w_quotient, w_remainder;
  logic [DataWidth-1:0]   w_quot_fix, w_rem_fix;
  logic                   w_accept;

  assign w_op1_neg = signed_div_input & opdata1_input[DataWidth-1];
  assign w_op2_neg = signed_div_input & opdata2_input[DataWidth-1];
  assign w_op1_abs = w_op1_neg ? (-opdata1_input) : opdata1_input;
  assign w_op2_abs = w_op2_neg ? (-opdata2_input) : opdata2_input;

  assign w_accept = (start_input == DivStart) && (annul_input == 1'b0);

  // The minuend carries one extra bit so divisors above 2^(W-1) never truncate
  // the partial remainder; when no borrow occurs the true difference fits W bits.
  assign w_minuend = r_dividend[2*DataWidth:DataWidth];
  assign w_borrow  = (w_minuend < {1'b0, r_divisor});
  assign w_diff    = w_minuend[DataWidth-1:0] - r_divisor;

  assign w_quotient  = r_dividend[DataWidth-1:0];
  assign w_remainder = r_dividend[2*DataWidth:DataWidth+1];
  assign w_quot_fix  = (r_op1_neg ^ r_op2_neg) ? (-w_quotient) : w_quotient;
  assign w_rem_fix   = r_op1_neg ? (-w_remainder) : w_remainder;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= DivFree;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath and output update logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_op1_neg_nxt  = r_op1_neg;
    w_op2_neg_nxt  = r_op2_neg;
    w_result_nxt   = result_output;
    w_ready_nxt    = ready_output;

    case (r_state)
      DivFree: begin
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = ZeroResult;
        if (w_accept) begin
          if (opdata2_input == {DataWidth{1'b0}}) begin
            w_state_nxt = DivByZero;
          end else begin
            w_state_nxt    = DivOn;
            w_count_nxt    = CountZero;
            w_dividend_nxt = {{DataWidth{1'b0}}, w_op1_abs, 1'b0};
            w_divisor_nxt  = w_op2_abs;
            w_op1_neg_nxt  = w_op1_neg;
            w_op2_neg_nxt  = w_op2_neg;
          end
        end else begin
          w_state_nxt = DivFree;
        end
      end

      DivByZero: begin
        w_dividend_nxt = ZeroDividend;
        w_state_nxt    = DivEnd;
      end

      DivOn: begin
        if (annul_input == 1'b1) begin
          w_state_nxt  = DivFree;
          w_count_nxt  = CountZero;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = ZeroResult;
        end else if (r_count != LastCount) begin
          if (w_borrow) begin
            w_dividend_nxt = {r_dividend[DivW-2:0], 1'b0};
          end else begin
            w_dividend_nxt = {w_diff, r_dividend[DataWidth-1:0], 1'b1};
          end
          w_count_nxt = r_count + CountOne;
        end else begin
          w_dividend_nxt = {w_rem_fix, r_dividend[DataWidth], w_quot_fix};
          w_state_nxt    = DivEnd;
        end
      end

      DivEnd: begin
        if (start_input == DivStop) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = ZeroResult;
        end else begin
          w_ready_nxt  = DivResultReady;
          w_result_nxt = {w_remainder, w_quotient};
        end
      end

      default: begin
        w_state_nxt  = DivFree;
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = ZeroResult;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count       <= CountZero;
      r_dividend    <= ZeroDividend;
      r_divisor     <= {DataWidth{1'b0}};
      r_op1_neg     <= 1'b0;
      r_op2_neg     <= 1'b0;
      result_output <= ZeroResult;
      ready_output  <= DivResultNotReady;
    end else begin
      r_count       <= w_count_nxt;
      r_dividend    <= w_dividend_nxt;
      r_divisor     <= w_divisor_nxt;
      r_op1_neg     <= w_op1_neg_nxt;
      r_op2_neg     <= w_op2_neg_nxt;
      result_output <= w_result_nxt;
      ready_output  <= w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: latency/arithmetic reference model plus
// directed edge cases and randomized divisions with annul and reset.
module tb_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        signed_div_input = 1'b0;
  logic [31:0] opdata1_input = 32'd0;
  logic [31:0] opdata2_input = 32'd0;
  logic        start_input = 1'b0;
  logic        annul_input = 1'b0;
  logic [63:0] result_output;
  logic        ready_output;

  int n_cmp = 0;
  int n_err = 0;

  div dut (
    .clock            (clock),
    .reset            (reset),
    .signed_div_input (signed_div_input),
    .opdata1_input    (opdata1_input),
    .opdata2_input    (opdata2_input),
    .start_input      (start_input),
    .annul_input      (annul_input),
    .result_output    (result_output),
    .ready_output     (ready_output)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic [31:0] q32, r32;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      q32 = q[31:0];
      r32 = r[31:0];
    end else begin
      q32 = a / b;
      r32 = a % b;
    end
    return {r32, q32};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accept -> fixed latency (34, or 2 for a zero divisor),
  // annul aborts only while computing, result held while start stays high.
  bit          m_valid = 1'b0;
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_len = 0;
  logic [63:0] m_val = 64'd0;
  logic        exp_ready = 1'b0;
  logic [63:0] exp_result = 64'd0;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0; exp_ready = 1'b0; exp_result = 64'd0; m_valid = 1'b1;
    end else if (!m_busy) begin
      exp_ready = 1'b0; exp_result = 64'd0;
      if (start_input && !annul_input) begin
        m_busy = 1'b1; m_age = 0;
        m_len = (opdata2_input == 32'd0) ? 2 : 34;
        m_val = ref_div(opdata1_input, opdata2_input, signed_div_input);
      end
    end else if (m_len == 34 && m_age <= 32 && annul_input) begin
      m_busy = 1'b0; exp_ready = 1'b0; exp_result = 64'd0;
    end else if (m_age >= m_len - 1) begin
      if (start_input) begin
        exp_ready = 1'b1; exp_result = m_val;
      end else begin
        m_busy = 1'b0; exp_ready = 1'b0; exp_result = 64'd0;
      end
    end else begin
      m_age++;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("cyc_ready", {63'd0, ready_output}, {63'd0, exp_ready});
      check("cyc_result", result_output, exp_result);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input string name, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (ready_output !== 1'b1 && cyc < 60);
    if (ready_output !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got no ready after %0d cycles, required ready", name, cyc);
    end
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int lat, input logic [63:0] exp);
    int cyc;
    check({name, "_model"}, ref_div(a, b, s), exp);
    opdata1_input = a; opdata2_input = b; signed_div_input = s; start_input = 1'b1;
    tick();
    opdata1_input = $urandom; opdata2_input = $urandom; signed_div_input = ~s;
    wait_ready(name, cyc);
    check({name, "_lat"}, 64'(cyc), 64'(lat));
    check({name, "_res"}, result_output, exp);
    start_input = 1'b0;
    tick();
    check({name, "_drop_ready"}, {63'd0, ready_output}, 64'd0);
    check({name, "_drop_res"}, result_output, 64'd0);
    tick();
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    bit done;
    repeat (3) tick();
    check("reset_ready", {63'd0, ready_output}, 64'd0);
    check("reset_result", result_output, 64'd0);
    reset = 1'b0;
    tick();

    directed("u100_7", 32'd100, 32'd7, 1'b0, 34, 64'h00000002_0000000E);
    directed("s_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 34, 64'hFFFFFFFF_FFFFFFFD);
    directed("divzero", 32'h1234_5678, 32'd0, 1'b0, 2, 64'd0);
    directed("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 64'h00000000_80000000);
    directed("x_by_1", 32'hDEAD_BEEF, 32'd1, 1'b0, 34, 64'h00000000_DEADBEEF);
    directed("small_dvd", 32'd5, 32'd9, 1'b0, 34, 64'h00000005_00000000);
    directed("u_big_dvs", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 34, 64'h7FFFFFFE_00000001);

    // Annul 10 cycles into a division, then a fresh 9 / 3.
    opdata1_input = 32'd1000; opdata2_input = 32'd3; signed_div_input = 1'b0; start_input = 1'b1;
    tick();
    repeat (10) tick();
    annul_input = 1'b1; start_input = 1'b0;
    tick();
    annul_input = 1'b0;
    check("annul_ready", {63'd0, ready_output}, 64'd0);
    check("annul_res", result_output, 64'd0);
    tick();
    directed("after_annul", 32'd9, 32'd3, 1'b0, 34, 64'h00000000_00000003);

    // Reset 20 cycles into a division with start still high.
    opdata1_input = 32'd77; opdata2_input = 32'd5; start_input = 1'b1;
    tick();
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_ready", {63'd0, ready_output}, 64'd0);
    check("rst_mid_res", result_output, 64'd0);
    tick();
    reset = 1'b0;
    opdata1_input = 32'd77; opdata2_input = 32'd5;
    tick();
    wait_ready("rst_restart", cyc);
    check("rst_restart_lat", 64'(cyc), 64'd34);
    check("rst_restart_res", result_output, 64'h00000002_0000000F);
    start_input = 1'b0;
    tick();
    tick();

    // Randomized divisions with occasional annul and varying hold times.
    for (int n = 0; n < 150; n++) begin
      opdata1_input = pick_op(); opdata2_input = pick_op();
      signed_div_input = 1'($urandom_range(0, 1));
      start_input = 1'b1;
      tick();
      opdata1_input = $urandom; opdata2_input = $urandom;
      done = 1'b0;
      for (int c = 0; c < 45 && !done; c++) begin
        if (ready_output === 1'b1) begin
          repeat ($urandom_range(0, 2)) tick();
          start_input = 1'b0;
          annul_input = 1'($urandom_range(0, 3) == 0);
          tick();
          done = 1'b1;
        end else if ($urandom_range(0, 59) == 0) begin
          annul_input = 1'b1; start_input = 1'b0;
          tick();
          done = 1'b1;
        end else begin
          tick();
        end
      end
      if (!done) begin
        n_cmp++; n_err++;
        $display("FAIL rand_timeout: got no ready in division %0d, required ready", n);
        start_input = 1'b0;
        tick();
      end
      annul_input = 1'b0;
      repeat ($urandom_range(1, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
